// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and defaults for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_STALL = 2'd2, ST_HALT = 2'd3} state_e;
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_STALL = ST_STALL;
  localparam logic [1:0] S_HALT = ST_HALT;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam int IMEM_DEPTH_DEF = 17;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: saturating issue and stall-cycle counters, cleared when a run starts
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        issue,
  input  logic        stall_cyc,
  output logic [31:0] fetch_cnt,
  output logic [15:0] stall_cnt
);
  // count up on each event, stick at all-ones, restart from zero on a new run
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= clr ? '0 : (issue && !(&fetch_cnt)) ? fetch_cnt + 32'd1 : fetch_cnt;
      stall_cnt <= clr ? '0 : (stall_cyc && !(&stall_cnt)) ? stall_cnt + 16'd1 : stall_cnt;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing and instruction issue FSM; FETCH_PERF_CNT_EN adds perf counters
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        busy,
  output logic        done,
  output logic        err_misalign,
  output logic [31:0] fetch_cnt,
  output logic [15:0] stall_cnt
);
  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);
  logic [1:0] state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic in_range, launch, redirect, bad_tgt, issue;
  assign imem_addr = pc;
  assign in_range = {2'b00, pc[31:2]} < DEPTH_W;
  assign launch = start && (state == S_IDLE || state == S_HALT);
  assign busy = state == S_FETCH || state == S_STALL;
  assign redirect = busy && branch_taken;
  assign bad_tgt = |branch_target[1:0];
  assign issue = state == S_FETCH && !branch_taken && !stall && in_range;
  assign done = state == S_HALT && !err_misalign;
  // next state and pc: start, then redirect (over stall), then sequential flow
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    if (launch) begin
      state_nxt = S_FETCH;
      pc_nxt = RESET_PC;
    end else if (redirect) begin
      state_nxt = bad_tgt ? S_HALT : S_FETCH;
      pc_nxt = bad_tgt ? pc : branch_target;
    end else if (state == S_FETCH) begin
      state_nxt = stall ? S_STALL : in_range ? S_FETCH : S_HALT;
      pc_nxt = issue ? pc + WORD_BYTES : pc;
    end else if (state == S_STALL) begin
      state_nxt = stall ? S_STALL : S_FETCH;
    end
  end
  // state, pc, issue register and sticky misalignment flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      instr_out <= '0;
      pc_out <= '0;
      instr_valid <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      instr_valid <= issue;
      if (issue) begin
        instr_out <= imem_rdata;
        pc_out <= pc;
      end
      err_misalign <= launch ? 1'b0 : err_misalign | (redirect & bad_tgt);
    end
`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (launch),
    .issue     (issue),
    .stall_cyc (state == S_STALL),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0, imem_addr, imem_rdata, instr_out, pc_out;
  logic instr_valid, busy, done, err_misalign;
  logic [31:0] fetch_cnt;
  logic [15:0] stall_cnt;
  int total = 0, passed = 0;
  logic [31:0] exp_q[$];

  fetch_sequencer #(.IMEM_DEPTH(17), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .instr_valid(instr_valid), .busy(busy), .done(done),
    .err_misalign(err_misalign), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = word_of(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  // scoreboard: every issue must match the oldest expected pc and its memory word
  always @(negedge clk)
    if (rst_n && instr_valid) begin
      total++;
      assert (exp_q.size() != 0) passed++;
      else $error("FAIL unexpected_issue observed pc=%0h expected=no issue", pc_out);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("issue_pc", pc_out, e);
        chk("issue_instr", instr_out, word_of(e));
      end
    end

  initial begin
    #2;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("idle_no_start", 32'(busy), 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    push_run(32'h0, 17);
    chk("start_busy", 32'(busy), 1);
    step(2);
    chk("at_pc8", imem_addr, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_valid", 32'(instr_valid), 0);
      chk("stall_pc_hold", imem_addr, 32'h8);
      chk("stall_busy", 32'(busy), 1);
    end
    stall = 1'b0;
    step(1);
    chk("release_no_fetch", 32'(instr_valid), 0);
    for (int i = 0; i < 100 && !done; i++) step(1);
    chk("run_done", 32'(done), 1);
    chk("run_busy", 32'(busy), 0);
    chk("run_last_pc", pc_out, 32'h40);
    chk("run_queue_empty", 32'(exp_q.size()), 0);
    chk("fetch_cnt_17", fetch_cnt, PERF ? 32'd17 : 32'd0);
    chk("stall_cnt_3", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
    branch_taken = 1'b1;
    branch_target = 32'h0;
    step(1);
    branch_taken = 1'b0;
    chk("halt_ignores_branch", imem_addr, 32'h44);
    chk("halt_valid", 32'(instr_valid), 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("cnt_clear_fetch", fetch_cnt, 0);
    chk("cnt_clear_stall", 32'(stall_cnt), 0);
    chk("restart_done", 32'(done), 0);
    push_run(32'h0, 9);
    push_run(32'hC, 2);
    step(9);
    chk("at_pc24", imem_addr, 32'h24);
    branch_taken = 1'b1;
    branch_target = 32'hC;
    step(1);
    branch_taken = 1'b0;
    chk("squash_valid", 32'(instr_valid), 0);
    chk("redirect_pc", imem_addr, 32'hC);
    step(2);
    exp_q.push_back(32'h30);
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h30;
    step(1);
    stall = 1'b0;
    branch_taken = 1'b0;
    chk("br_stall_pc", imem_addr, 32'h30);
    chk("br_stall_valid", 32'(instr_valid), 0);
    step(1);
    branch_taken = 1'b1;
    branch_target = 32'hE;
    step(1);
    branch_taken = 1'b0;
    chk("misalign_err", 32'(err_misalign), 1);
    chk("misalign_done", 32'(done), 0);
    chk("misalign_busy", 32'(busy), 0);
    chk("misalign_pc_hold", imem_addr, 32'h34);
    chk("misalign_fetch_cnt", fetch_cnt, PERF ? 32'd12 : 32'd0);
    step(2);
    chk("misalign_sticky", 32'(err_misalign), 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("start_clears_err", 32'(err_misalign), 0);
    chk("start_pc0", imem_addr, 32'h0);
    exp_q.push_back(32'h0);
    step(2);
    chk("pre_rst_valid", 32'(instr_valid), 1);
    chk("pre_rst_pc", pc_out, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(instr_valid), 0);
    chk("async_pc_out", pc_out, 0);
    chk("async_instr_out", instr_out, 0);
    chk("async_imem_addr", imem_addr, 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_fetch_cnt", fetch_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_no_issue", 32'(instr_valid), 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    step(1);
    branch_taken = 1'b0;
    exp_q.push_back(32'h40);
    step(2);
    chk("oor_branch_done", 32'(done), 1);
    chk("oor_branch_pc", imem_addr, 32'h44);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The parameter list SHALL be: IMEM_DEPTH, 17, instruction-memory size in 32-bit words.
REQ-002 The parameter list SHALL be: RESET_PC, 32'h0, byte address loaded into PC on reset and on start.
REQ-003 The port list SHALL be: clk  in  1  single clock; all state on rising edge.
REQ-004 The port list SHALL be: rst_n  in  1  asynchronous, active-low reset.
REQ-005 The port list SHALL be: start  in  1  one-cycle pulse; begins fetching from RESET_PC.
REQ-006 The port list SHALL be: stall  in  1  hold PC and suppress issue this cycle.
REQ-007 The port list SHALL be: branch_taken  in  1  redirect request from execute.
REQ-008 The port list SHALL be: branch_target  in  32  byte address of the redirect.
REQ-009 The port list SHALL be: imem_addr  out  32  byte address to instruction memory; memory returns the word combinationally.
REQ-010 The port list SHALL be: imem_rdata  in  32  instruction word at imem_addr.
REQ-011 The port list SHALL be: instr_out  out  32  registered instruction issued to decode.
REQ-012 The port list SHALL be: pc_out  out  32  byte address of instr_out.
REQ-013 The port list SHALL be: instr_valid  out  1  instr_out/pc_out valid this cycle.
REQ-014 The port list SHALL be: busy  out  1  high in FETCH or STALL.
REQ-015 The port list SHALL be: done  out  1  high in HALT because the program ran off the end of memory.
REQ-016 The port list SHALL be: err_misalign  out  1  sticky; a branch target was not a multiple of 4.
REQ-017 The port list SHALL be: fetch_cnt  out  32  and stall_cnt  out  16  performance counters.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, STALL and HALT; it SHALL reset to IDLE.
REQ-019 IDLE SHALL go to FETCH on start, with pc <= RESET_PC; start is ignored in FETCH/STALL and restarts from HALT.
REQ-020 imem_addr SHALL equal pc combinationally in every state.
REQ-021 In FETCH with stall=0 and branch_taken=0: instr_out <= imem_rdata, pc_out <= pc, instr_valid <= 1 next cycle, pc <= pc+4 (1-cycle latency).
REQ-022 stall=1 in FETCH SHALL move to STALL, hold pc, and give instr_valid=0 next cycle; STALL SHALL return to FETCH in the first cycle stall=0, with no fetch that cycle.
REQ-023 branch_taken SHALL take priority over stall in FETCH and STALL: pc <= branch_target, the word fetched that cycle SHALL be squashed (instr_valid=0 next cycle), and the state SHALL become FETCH.
REQ-024 A branch_target with bits [1:0] != 0 SHALL set err_misalign, drop the redirect and move to HALT.
REQ-025 When pc/4 >= IMEM_DEPTH in FETCH (sequential or branched), no instruction SHALL issue and the state SHALL go to HALT with done=1.
REQ-026 In HALT and IDLE, instr_valid SHALL be 0 and pc SHALL hold; branch_taken SHALL be ignored.
REQ-027 pc arithmetic SHALL be 32-bit unsigned and wrap modulo 2^32; the out-of-range rule applies after the wrap.

Reset
REQ-028 Asserting rst_n low SHALL immediately and asynchronously force state=IDLE, pc=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, err_misalign=0, fetch_cnt=0 and stall_cnt=0, also during fetch.
REQ-029 The first fetch after rst_n deasserts SHALL require start.

Configuration
REQ-030 With FETCH_PERF_CNT_EN defined, fetch_cnt SHALL count issued instructions and stall_cnt SHALL count STALL cycles, saturating at maximum and clearing on start; without it, both SHALL be driven constant 0 with no counter flops.

Structure
REQ-031 The package fetch_pkg SHALL hold the state enum, WORD_BYTES=4 and the default IMEM_DEPTH/RESET_PC constants.
REQ-032 The counters SHALL live in one sub-module, fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-033 Reset, then start, no stalls, IMEM_DEPTH=17 -> 17 valid issues with pc_out 0,4,...,64, then done=1 and busy=0.
REQ-034 stall high for 3 cycles at pc=8 -> no issue during the stall, and pc=8 issues once after release with no duplicate and no skip.
REQ-035 branch_taken with target 0x0C while fetching 0x24 -> 0x24 is squashed and the next valid pc_out is 0x0C.
REQ-036 branch_taken with target 0x0E -> err_misalign=1 and HALT; start then clears it and fetches from 0.
REQ-037 Branch and stall in the same cycle -> redirect is taken; rst_n low mid-fetch -> all outputs 0 immediately.
REQ-038 With FETCH_PERF_CNT_EN, the REQ-033 run plus one 3-cycle stall -> fetch_cnt=17 and stall_cnt=3; without it, both read 0.
